// File: rtl/adder_counter_stage.sv
// ---------------------------------------------------------------------------
// adder_counter_stage
//
// Sequencing stage wrapped around an external WIDTH-bit ripple adder. Together
// with the adder it forms a programmable step/limit counter: this block holds
// the count register and presents it as adder operand a. It presents the step
// as operand b. It then takes the sum and carry back and picks the next count:
// advance, wrap to 0, clamp to the limit, or load.
//
// Optional feature macro: COUNTER_SATURATE_EN
//   When defined, a free-running count that passes the limit clamps to the
//   limit and holds there, instead of wrapping to 0. One-shot mode is the same
//   in both builds.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      pulse: IDLE/DONE -> RUN (DONE -> RUN also zeroes count)
//   stop      in   1      pulse: any state -> IDLE, count kept; beats start
//   en        in   1      advance enable while in RUN
//   one_shot  in   1      1 = stop at limit (DONE), 0 = free-run
//   load      in   1      synchronous load of min(load_val, limit)
//   load_val  in   WIDTH  load value
//   step      in   WIDTH  increment per enabled cycle
//   limit     in   WIDTH  inclusive terminal value, sampled live
//   add_a     out  WIDTH  adder operand a (= count)
//   add_b     out  WIDTH  adder operand b (step while advancing, else 0)
//   add_cin   out  1      adder carry-in, tied 0
//   add_sum   in   WIDTH  adder sum
//   add_cout  in   1      adder carry-out
//   count     out  WIDTH  registered count
//   wrap      out  1      one-cycle pulse on a wrap or clamp event
//   done      out  1      high while in DONE
//   ovf       out  1      sticky adder carry-out; cleared by an accepted start
// ---------------------------------------------------------------------------
module adder_counter_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             one_shot,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic             adv_en;      // adder is being fed the step this cycle
  logic             count_adv;   // the sum is actually taken this cycle
  logic             start_acc;   // start that changes state
  logic [WIDTH:0]   nxt;
  logic             terminal;

  // Saturating minimum used for loads: a load never places count above limit.
  function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] v,
                                                      input logic [WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign adv_en    = (state_q == RUN) && en;
  assign count_adv = adv_en && !stop;
  assign start_acc = start && !stop && (state_q != RUN);

  // Compare the full carry-extended sum, so a sum past 2^WIDTH-1 is also
  // recognised as beyond the limit.
  assign nxt      = {add_cout, add_sum};
  assign terminal = nxt > {1'b0, limit};

  assign add_a   = count_q;
  assign add_b   = adv_en ? step : '0;
  assign add_cin = 1'b0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    // State: stop beats start. A load suppresses the one-shot DONE transition,
    // because the load replaces the counting step on that cycle.
    if (stop) begin
      state_d = IDLE;
    end else if (start_acc) begin
      state_d = RUN;
    end else if (count_adv && terminal && one_shot && !load) begin
      state_d = DONE;
    end

    // Sticky overflow. An accepted start and an advance never coincide, since
    // an accepted start is only possible outside RUN.
    if (start_acc) begin
      ovf_d = 1'b0;
    end else if (count_adv && add_cout) begin
      ovf_d = 1'b1;
    end

    // Count: load beats everything, stop freezes, and DONE->RUN zeroes count.
    if (load) begin
      count_d = clamp_to_limit(load_val, limit);
    end else if (stop) begin
      count_d = count_q;
    end else if (start_acc && (state_q == DONE)) begin
      count_d = '0;
    end else if (count_adv) begin
      if (!terminal) begin
        count_d = add_sum;
      end else if (one_shot) begin
        count_d = limit;
        wrap_d  = 1'b1;
      end else begin
`ifdef COUNTER_SATURATE_EN
        // Holding at the clamp is not a new event. Only the first clamp pulses.
        count_d = limit;
        wrap_d  = (count_q != limit);
`else
        count_d = '0;
        wrap_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = (state_q == DONE);
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_adder_counter_stage.sv
// Bench for adder_counter_stage (WIDTH=4). A behavioural ripple adder closes
// the loop around the stage. Directed vectors carry hand-computed expectations.
module tb_adder_counter_stage;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, stop, en, one_shot, load;
  logic [W-1:0] load_val, step, limit;
  logic [W-1:0] add_a, add_b, add_sum, count;
  logic         add_cin, add_cout, wrap, done, ovf;
  logic [W:0]   adder_res;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // External adder the stage is designed to drive.
  assign adder_res = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum   = adder_res[W-1:0];
  assign add_cout  = adder_res[W];

  adder_counter_stage #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .one_shot (one_shot),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .limit    (limit),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .count    (count),
    .wrap     (wrap),
    .done     (done),
    .ovf      (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; one_shot = 1'b0;
    load = 1'b0; load_val = '0; step = '0; limit = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_done",  32'(done),  0);
    check("rst_wrap",  32'(wrap),  0);
    check("rst_ovf",   32'(ovf),   0);
    check("add_cin",   32'(add_cin), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: limit=15 step=1 free-run, 0..15 then wrap to 0 with carry-out
    limit = 4'd15; step = 4'd1; en = 1'b1;
    check("idle_add_b", 32'(add_b), 0);
    pulse_start();
    check("t1_start_cnt", 32'(count), 0);
    check("t1_add_b", 32'(add_b), 1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("t1_cnt", 32'(count), 32'(i));
    end
    check("t1_nowrap_15", 32'(wrap), 0);
    check("t1_ovf_pre", 32'(ovf), 0);
    tick();
    check("t1_wrap_cnt", 32'(count), 0);
    check("t1_wrap", 32'(wrap), 1);
    check("t1_ovf", 32'(ovf), 1);
    tick();
    check("t1_after_cnt", 32'(count), 1);
    check("t1_wrap_1cyc", 32'(wrap), 0);

    // 2: limit=9 step=3 free-run, 0,3,6,9,0,3; start clears ovf
    pulse_stop();
    check("t2_stop_keep", 32'(count), 1);
    check("t2_idle_add_b", 32'(add_b), 0);
    do_load(4'd0);
    limit = 4'd9; step = 4'd3;
    check("t2_ovf_sticky", 32'(ovf), 1);
    pulse_start();
    check("t2_ovf_clr", 32'(ovf), 0);
    check("t2_cnt0", 32'(count), 0);
    tick(); check("t2_cnt3", 32'(count), 3);
    tick(); check("t2_cnt6", 32'(count), 6);
    tick(); check("t2_cnt9", 32'(count), 9);
    check("t2_nowrap9", 32'(wrap), 0);
    tick(); check("t2_wrap_cnt", 32'(count), 0);
    check("t2_wrap", 32'(wrap), 1);
    tick(); check("t2_cnt3b", 32'(count), 3);
    check("t2_ovf", 32'(ovf), 0);

    // 3: one_shot limit=5 step=2 -> 0,2,4,5 then DONE
    pulse_stop();
    do_load(4'd0);
    one_shot = 1'b1; limit = 4'd5; step = 4'd2;
    pulse_start();
    tick(); check("t3_cnt2", 32'(count), 2);
    tick(); check("t3_cnt4", 32'(count), 4);
    check("t3_not_done", 32'(done), 0);
    tick(); check("t3_cnt5", 32'(count), 5);
    check("t3_done", 32'(done), 1);
    check("t3_wrap", 32'(wrap), 1);
    tick(); check("t3_hold5", 32'(count), 5);
    check("t3_done_hold", 32'(done), 1);
    check("t3_wrap_off", 32'(wrap), 0);
    check("t3_done_add_b", 32'(add_b), 0);
    pulse_start();
    check("t3_restart_cnt", 32'(count), 0);
    check("t3_restart_done", 32'(done), 0);
    check("t3_restart_ovf", 32'(ovf), 0);
    tick(); check("t3_run_again", 32'(count), 2);
    one_shot = 1'b0;

    // 4: load 12 with limit 9 in RUN -> 9, no wrap; then wrap from 9
    limit = 4'd9; step = 4'd1;
    do_load(4'd12);
    check("t4_load_clamp", 32'(count), 9);
    check("t4_load_nowrap", 32'(wrap), 0);
    tick(); check("t4_wrap_cnt", 32'(count), 0);
    check("t4_wrap", 32'(wrap), 1);
    tick(); check("t4_cnt1", 32'(count), 1);
    // live limit below count wraps on the next enabled cycle
    limit = 4'd0;
    tick(); check("t4_live_lim_cnt", 32'(count), 0);
    check("t4_live_lim_wrap", 32'(wrap), 1);
    // step=0 and en=0 hold
    limit = 4'd9;
    do_load(4'd4);
    step = 4'd0;
    tick(); check("t4_step0_hold", 32'(count), 4);
    check("t4_step0_nowrap", 32'(wrap), 0);
    step = 4'd1; en = 1'b0;
    tick(); check("t4_en0_hold", 32'(count), 4);
    check("t4_en0_add_b", 32'(add_b), 0);

    // 5: set ovf, park at 5 in RUN, then asynchronous reset mid-cycle
    en = 1'b1; limit = 4'd15;
    do_load(4'd15);
    tick(); check("t5_ovf_set", 32'(ovf), 1);
    en = 1'b0;
    do_load(4'd5);
    check("t5_cnt5", 32'(count), 5);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_cnt", 32'(count), 0);
    check("t5_rst_wrap", 32'(wrap), 0);
    check("t5_rst_done", 32'(done), 0);
    check("t5_rst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1; step = 4'd1;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t5_ss_add_b", 32'(add_b), 0);
    tick(); check("t5_ss_idle_cnt", 32'(count), 0);

`ifdef COUNTER_SATURATE_EN
    // 6: saturate, limit=15 step=4 from 12 -> 15,15,15 with one wrap pulse
    limit = 4'd15; step = 4'd4;
    do_load(4'd12);
    pulse_start();
    check("t6_cnt12", 32'(count), 12);
    tick(); check("t6_cnt15a", 32'(count), 15);
    check("t6_wrap", 32'(wrap), 1);
    check("t6_ovf", 32'(ovf), 1);
    tick(); check("t6_cnt15b", 32'(count), 15);
    check("t6_wrap_once", 32'(wrap), 0);
    tick(); check("t6_cnt15c", 32'(count), 15);
    check("t6_wrap_once2", 32'(wrap), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
